dcache_miss_handler: RTL
========================

# dcache_miss_handler

Memory-side responder for the data cache in the memory stage. On a load/store miss, it writes back the dirty victim block as a beat burst and fetches the missing block as a beat burst. It then presents the assembled block to the cache with a one-cycle block write enable. It sits between the memory stage (miss, dirty, victim address/block in; refill block and block write enable out) and the external memory port.

## Interface
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, 64, memory beat width
- BLOCK_WIDTH, 512, cache block width; BEATS = BLOCK_WIDTH/DATA_WIDTH (8), beat counter width = log2(BEATS)
- clk_i  in  1  single clock, all state changes on rising edge
- arst_i  in  1  reset, synchronous, active-high
- miss_i  in  1  memory access that missed the cache (mem_access & ~hit)
- dirty_i  in  1  victim block is dirty
- addr_i  in  ADDR_WIDTH  miss address
- addr_wb_i  in  ADDR_WIDTH  victim block address
- victim_block_i  in  BLOCK_WIDTH  victim block contents
- refill_block_o  out  BLOCK_WIDTH  assembled refill block
- block_we_o  out  1  one-cycle refill write enable to the cache
- stall_o  out  1  pipeline stall request
- mem_req_valid_o  out  1  burst request valid
- mem_req_ready_i  in  1  burst request accepted
- mem_req_we_o  out  1  1 = write burst, 0 = read burst
- mem_req_addr_o  out  ADDR_WIDTH  block-aligned burst address (low log2(BLOCK_WIDTH/8) bits zero)
- mem_wdata_o  out  DATA_WIDTH  write beat
- mem_wvalid_o  out  1  write beat valid
- mem_wready_i  in  1  write beat accepted
- mem_rdata_i  in  DATA_WIDTH  read beat
- mem_rvalid_i  in  1  read beat valid
- mem_rready_o  out  1  read beat ready

## Operation
- States are IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA and FILL.
- **IDLE:** when miss_i=1, latch the block-aligned addr_i.
  - If dirty_i=1, also latch the block-aligned addr_wb_i and victim_block_i, then go to WB_REQ.
  - Otherwise go to RD_REQ.
- **WB_REQ:** mem_req_valid_o=1, mem_req_we_o=1, mem_req_addr_o = latched victim address. When mem_req_ready_i=1, clear the beat counter and go to WB_DATA.
- **WB_DATA:** mem_wvalid_o=1, mem_wdata_o = victim bits [DATA_WIDTH*k +: DATA_WIDTH], where k is the beat counter.
  - k increments on each cycle with mem_wready_i=1.
  - On the accepted beat k=BEATS-1, go to RD_REQ.
- **RD_REQ:** mem_req_valid_o=1, mem_req_we_o=0, mem_req_addr_o = latched miss address. When mem_req_ready_i=1, clear k and go to RD_DATA.
- **RD_DATA:** mem_rready_o=1.
  - On each cycle with mem_rvalid_i=1, store mem_rdata_i into refill bits [DATA_WIDTH*k +: DATA_WIDTH] and increment k.
  - On beat BEATS-1, go to FILL.
- **FILL:** block_we_o=1 for exactly one cycle, then go to IDLE.
  - refill_block_o is the refill register; it is stable from FILL until the next RD_DATA.
- Beats run in ascending address order with beat 0 at the lowest address. The counter wraps BEATS-1 to 0 only via the state change; it never overflows inside a burst.
- mem_req_addr_o is driven only in the REQ states, 0 otherwise.
- mem_req_valid_o, once asserted, holds with constant address and we until ready.
- mem_rvalid_i outside RD_DATA is ignored. mem_wready_i outside WB_DATA is ignored.
- stall_o = (state != IDLE) | miss_i, combinational. It covers the FILL cycle.
- miss_i and dirty_i are sampled only in IDLE; changes in other states are ignored.

## Timing
- **Reset:** when arst_i=1 at a clock edge, the state goes to IDLE and k, the address latches and the refill register clear to 0. All outputs are 0 the following cycle, except stall_o, which follows miss_i.
- **Reset mid-operation:** a reset during any burst abandons it. No block_we_o follows, and refill_block_o reads 0.
- **Clean miss, memory always ready/valid:** miss seen in cycle 0, request handshake in cycle 1, read beats in cycles 2–9, block_we_o in cycle 10, IDLE in cycle 11. Latency is 11 cycles.
- **Dirty miss, memory always ready/valid:** write request in cycle 1, write beats in cycles 2–9, read request in cycle 10, read beats in cycles 11–18, FILL in cycle 19.
- **Wait states:** each cycle with ready=0 or rvalid=0 adds exactly one cycle. Beat data and the counter hold.
- **Back-to-back misses:** IDLE → new request no earlier than the cycle after FILL. The cache's post-fill hit drops miss_i, so there is no spurious re-request.

## Test plan
- **Clean miss:** addr_i=0x1048, dirty_i=0, memory returns beats 0x100+k with no wait states.
  - Required: one read request at 0x1040 with we=0; block_we_o pulses in cycle 10; refill_block_o bits [63:0]=0x100 and bits [511:448]=0x107.
- **Dirty miss:** addr_wb_i=0x2000, victim beats 0xA0+k, addr_i=0x3010.
  - Required: write request at 0x2000 with 8 beats 0xA0..0xA7 in order; then read request at 0x3000; FILL in cycle 19.
- **Backpressure:** mem_req_ready_i held low for 3 cycles; mem_wready_i and mem_rvalid_i toggle every other cycle.
  - Required: request valid, address and we held stable; no beat lost or duplicated; latency grows by exactly the number of stall cycles.
- **Reset mid-burst:** assert arst_i after the 4th read beat.
  - Required: next cycle state is IDLE, all memory outputs 0, refill_block_o=0; block_we_o never asserts.
- **Stray traffic:** mem_rvalid_i=1 with data 0xDEAD while IDLE, then a clean miss.
  - Required: the stray beat is ignored and refill contains only the burst data.
- **stall_o tracking:** verify stall_o=1 from the miss cycle through FILL inclusive, and 0 the cycle after.

Source files
------------

// File: rtl/dcache_miss_handler.sv
// Data-cache miss handler: writes back a dirty victim as a beat burst, then fetches the missing block as a beat burst and hands it to the cache with a one-cycle block write enable.
// Latency: clean miss 11 cycles from miss to IDLE (FILL in cycle 10), dirty miss FILL in cycle 19, with memory always ready/valid.
// Backpressure: each cycle with mem_req_ready_i/mem_wready_i/mem_rvalid_i low adds one cycle; request, address and beat data hold until accepted.
//
// Ports:
//   clk_i, arst_i                 clock, synchronous active-high reset
//   miss_i, dirty_i               miss request and victim-dirty flag (sampled in IDLE only)
//   addr_i, addr_wb_i             miss address and victim block address
//   victim_block_i                victim block contents
//   refill_block_o, block_we_o    assembled refill block and its one-cycle write enable
//   stall_o                       pipeline stall request
//   mem_req_*                     burst request channel (valid/ready, we, block-aligned addr)
//   mem_w*                        write beat channel
//   mem_r*                        read beat channel
module dcache_miss_handler #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   miss_i,
  input  logic                   dirty_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [ADDR_WIDTH-1:0]  addr_wb_i,
  input  logic [BLOCK_WIDTH-1:0] victim_block_i,
  output logic [BLOCK_WIDTH-1:0] refill_block_o,
  output logic                   block_we_o,
  output logic                   stall_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_wdata_o,
  output logic                   mem_wvalid_o,
  input  logic                   mem_wready_i,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  input  logic                   mem_rvalid_i,
  output logic                   mem_rready_o
);

  localparam int BEATS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-offset-within-block bits of an address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_DATA,
    RD_REQ,
    RD_DATA,
    FILL
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [ADDR_WIDTH-1:0] miss_addr, wb_addr;
  // Blocks viewed as beat arrays: element k occupies bits [DATA_WIDTH*k +: DATA_WIDTH].
  logic [BEATS-1:0][DATA_WIDTH-1:0] victim, refill;
  logic miss_take, rbeat_take;

  always_comb begin
    state_nxt       = state;
    beat_cnt_nxt    = beat_cnt;
    miss_take       = 1'b0;
    rbeat_take      = 1'b0;
    block_we_o      = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_wdata_o     = '0;
    mem_wvalid_o    = 1'b0;
    mem_rready_o    = 1'b0;
    case (state)
      IDLE: begin
        if (miss_i) begin
          miss_take = 1'b1;
          state_nxt = dirty_i ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = wb_addr;
        if (mem_req_ready_i) begin
          beat_cnt_nxt = '0;
          state_nxt    = WB_DATA;
        end
      end
      WB_DATA: begin
        mem_wvalid_o = 1'b1;
        mem_wdata_o  = victim[beat_cnt];
        if (mem_wready_i) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = RD_REQ;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      RD_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = miss_addr;
        if (mem_req_ready_i) begin
          beat_cnt_nxt = '0;
          state_nxt    = RD_DATA;
        end
      end
      RD_DATA: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i) begin
          rbeat_take = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = FILL;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      FILL: begin
        block_we_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The raw miss_i term lets the pipeline stall in the same cycle the miss is seen.
  assign stall_o        = (state != IDLE) | miss_i;
  assign refill_block_o = refill;

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      miss_addr <= '0;
      wb_addr   <= '0;
      refill    <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (miss_take) begin
        miss_addr <= addr_i & ALIGN_MASK;
        if (dirty_i) begin
          wb_addr <= addr_wb_i & ALIGN_MASK;
        end
      end
      if (rbeat_take) begin
        refill[beat_cnt] <= mem_rdata_i;
      end
    end
  end

  // Victim data is only ever read in WB_DATA after being loaded, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (miss_take && dirty_i) begin
      victim <= victim_block_i;
    end
  end

endmodule
